// File: rtl/mant_mul_seq.sv
`timescale 1ns/1ps
// Sequential mantissa multiplier: streams ROWS partial-product rows per pass into a
// shared external carry-save tree and folds its carry/sum pair into a 2N-bit accumulator.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one pass per cycle, accumulating tree_t + tree_s
// DONE  | product held on out_valid until out_ready
module mant_mul_seq #(
  parameter int N    = 58,
  parameter int W    = 116,
  parameter int ROWS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic              abort,
  output logic [ROWS*W-1:0] tree_rows,
  input  logic [W-1:0]      tree_t,
  input  logic [W-1:0]      tree_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      product,
  output logic              busy
);

  localparam int PASSES = (N + ROWS - 1) / ROWS;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;

  logic [W-1:0]  a_ext;
  logic [N-1:0]  b_k;
  int            row_base;

  assign a_ext     = {{(W-N){1'b0}}, a_q};
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign busy      = (state_q != IDLE);

  // Row k of pass p carries multiplier bit r = p*ROWS+k; bits beyond N yield zero rows.
  always_comb begin
    tree_rows = '0;
    b_k       = '0;
    row_base  = int'(pass_q) * ROWS;
    if (state_q == RUN) begin
      for (int k = 0; k < ROWS; k++) begin
        b_k = b_q >> (row_base + k);
        if ((row_base + k < N) && b_k[0]) begin
          tree_rows[k*W +: W] = a_ext << (row_base + k);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          pass_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          acc_d   = '0;
          pass_d  = '0;
          state_d = IDLE;
        end else begin
          acc_d  = acc_q + tree_t + tree_s;
          pass_d = pass_q + PW'(1);
          if (pass_q == LAST_PASS) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // abort takes priority so a cancelled result is never handed over
        if (abort) begin
          acc_d   = '0;
          pass_d  = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_mant_mul_seq.sv
`timescale 1ns/1ps
// Bench for mant_mul_seq: directed vector table, abort/reset corner sequences and
// random operands checked against plain a*b, with a carry-save tree model attached.
module tb_mant_mul_seq;

  localparam int N      = 58;
  localparam int W      = 116;
  localparam int ROWS   = 8;
  localparam int PASSES = (N + ROWS - 1) / ROWS;
  localparam logic [N-1:0] MAXN = {N{1'b1}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic              abort;
  logic [ROWS*W-1:0] tree_rows;
  logic [W-1:0]      tree_t;
  logic [W-1:0]      tree_s;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      product;
  logic              busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mant_mul_seq #(.N(N), .W(W), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .tree_rows (tree_rows),
    .tree_t    (tree_t),
    .tree_s    (tree_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  // Carry-save tree model: 3:2 compress all rows into a sum/carry pair.
  logic [W-1:0] cs_s, cs_c, cs_x, cs_ns, cs_nc;
  always_comb begin
    cs_s  = tree_rows[0 +: W];
    cs_c  = tree_rows[W +: W];
    cs_x  = '0;
    cs_ns = '0;
    cs_nc = '0;
    for (int k = 2; k < ROWS; k++) begin
      cs_x  = tree_rows[k*W +: W];
      cs_ns = cs_s ^ cs_c ^ cs_x;
      cs_nc = ((cs_s & cs_c) | (cs_s & cs_x) | (cs_c & cs_x)) << 1;
      cs_s  = cs_ns;
      cs_c  = cs_nc;
    end
    tree_s = cs_s;
    tree_t = cs_c;
  end

  int checks = 0;
  int errors = 0;
  int last_acc = -1;
  int nz_rows, nz_pass, nz_row;

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [63:0] t;
    int m;
    m = $urandom_range(0, 9);
    t = {$urandom(), $urandom()};
    if (m == 0) return '0;
    if (m == 1) return MAXN;
    if (m == 2) return t[N-1:0] & 58'hFF;
    return t[N-1:0];
  endfunction

  // Waits for in_ready, presents operands, returns at the negedge after the accept edge.
  task automatic accept(input logic [N-1:0] a_v, input logic [N-1:0] b_v, input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk_int({tag, " in_ready before accept"}, int'(in_ready), 1);
    in_valid = 1'b1;
    a = a_v;
    b = b_v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = rnd_op();
    b = rnd_op();
  endtask

  task automatic run_op(input logic [N-1:0] a_v, input logic [N-1:0] b_v,
                        input logic [W-1:0] exp_v, input int hold, input bit pre_ready,
                        input string tag);
    int lat;
    accept(a_v, b_v, tag);
    if (last_acc >= 0)
      chk_int({tag, " period"}, (cyc - last_acc >= PASSES + 1) ? PASSES + 1 : cyc - last_acc,
              PASSES + 1);
    last_acc = cyc;
    if (pre_ready) out_ready = 1'b1;
    lat = 0;
    nz_rows = 0;
    nz_pass = -1;
    nz_row = -1;
    while (!out_valid && lat < 40) begin
      for (int k = 0; k < ROWS; k++) begin
        if (tree_rows[k*W +: W] != '0) begin
          nz_rows++;
          nz_pass = lat;
          nz_row = k;
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk_int({tag, " latency"}, lat, PASSES);
    chk_vec({tag, " product"}, product, exp_v);
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_int({tag, " hold out_valid"}, int'(out_valid), 1);
        chk_vec({tag, " hold product"}, product, exp_v);
        chk_int({tag, " hold in_ready"}, int'(in_ready), 0);
        chk_int({tag, " hold rows zero"}, int'(tree_rows != '0), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_int({tag, " out_valid after handshake"}, int'(out_valid), 0);
    chk_int({tag, " in_ready after handshake"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] exp;
    int           hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, w;
    logic [N-1:0] ra, rb;

    vecs[0] = '{58'd1, 58'd1, 116'd1, 0};
    vecs[1] = '{MAXN, MAXN, 116'hF_FFFF_FFFF_FFFF_F800_0000_0000_0001, 0};
    vecs[2] = '{58'd3, 58'd1 << 57, 116'd3 << 57, 0};
    vecs[3] = '{58'd1000, 58'd3000, 116'd3000000, 5};
    vecs[4] = '{58'd0, MAXN, 116'd0, 1};
    vecs[5] = '{MAXN, 58'd1, {58'd0, MAXN}, 2};

    in_valid = 1'b0;
    a = '0;
    b = '0;
    abort = 1'b0;
    out_ready = 1'b0;

    #1;
    chk_int("reset in_ready", int'(in_ready), 0);
    chk_int("reset out_valid", int'(out_valid), 0);
    chk_int("reset busy", int'(busy), 0);
    chk_vec("reset product", product, '0);
    chk_int("reset rows zero", int'(tree_rows != '0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_int("post-reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, 1'b0, $sformatf("vec%0d", i));
      if (i == 2) begin
        chk_int("vec2 nonzero row count", nz_rows, 1);
        chk_int("vec2 nonzero pass", nz_pass, 7);
        chk_int("vec2 nonzero row", nz_row, 1);
      end
    end

    // abort in RUN at pass 3
    accept(58'd9, 58'd9, "abort_run");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk_int("abort_run busy", int'(busy), 0);
    chk_int("abort_run in_ready", int'(in_ready), 1);
    chk_vec("abort_run acc cleared", product, '0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk_int("abort_run out_valid pulses", pulses, 0);
    run_op(58'd5, 58'd7, 116'd35, 0, 1'b0, "after_abort");

    // abort in IDLE blocks acceptance
    in_valid = 1'b1;
    abort = 1'b1;
    a = 58'd3;
    b = 58'd3;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk_int("abort_idle busy", int'(busy), 0);
    end
    in_valid = 1'b0;
    abort = 1'b0;

    // abort together with out_ready in DONE
    accept(58'd6, 58'd7, "abort_done");
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    chk_int("abort_done reached", int'(out_valid), 1);
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    chk_int("abort_done out_valid", int'(out_valid), 0);
    chk_int("abort_done busy", int'(busy), 0);
    chk_vec("abort_done acc cleared", product, '0);

    // asynchronous reset in the middle of RUN
    accept(58'd11, 58'd13, "rst_mid");
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_int("rst_mid out_valid", int'(out_valid), 0);
    chk_int("rst_mid busy", int'(busy), 0);
    chk_int("rst_mid in_ready", int'(in_ready), 0);
    chk_vec("rst_mid product", product, '0);
    chk_int("rst_mid rows zero", int'(tree_rows != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_int("rst_mid in_ready released", int'(in_ready), 1);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk_int("rst_mid spurious out_valid", pulses, 0);

    last_acc = -1;
    for (int i = 0; i < 200; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      run_op(ra, rb, {{(W-N){1'b0}}, ra} * {{(W-N){1'b0}}, rb},
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
